dmac_channel: RTL and testbench

//  Per-channel transfer engine downstream of the DMAC main controller. Holds one channel's working

---
 rtl/dmac_channel.sv | 201 ++++++++++++++++++++
 tb/tb_dmac_channel.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_channel.sv
// Single-channel DMA transfer engine: moves Trans_sz beats from source to destination over an
// AHB master port, in chunks of up to BUF_DEPTH reads followed by the same number of writes.
//
// state     | meaning
// S_IDLE    | no working config, waiting for cfg_load
// S_CFG     | config held, waiting for Channel_en
// S_RD      | issuing read address phases for the current chunk
// S_RD_LAST | last read address accepted, waiting for its data
// S_WR      | issuing write address phases for the current chunk
// S_WR_LAST | last write address accepted, waiting for its data phase
// S_DONE    | transfer finished or errored, irq held until Channel_en drops
module dmac_channel #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_load,
  input  logic [ADDR_W-1:0] SAddr,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [CNT_W-1:0]  Trans_sz,
  input  logic [3:0]        Ctrl,
  input  logic              Channel_en,
  input  logic              HReady,
  input  logic [1:0]        HResp,
  input  logic [DATA_W-1:0] HRData,
  output logic [ADDR_W-1:0] HAddr,
  output logic [1:0]        HTrans,
  output logic              HWrite,
  output logic [2:0]        HSize,
  output logic [DATA_W-1:0] HWData,
  output logic              C_config,
  output logic              irq,
  output logic              err
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CFG     = 3'd1;
  localparam logic [2:0] S_RD      = 3'd2;
  localparam logic [2:0] S_RD_LAST = 3'd3;
  localparam logic [2:0] S_WR      = 3'd4;
  localparam logic [2:0] S_WR_LAST = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        hsize_q;
  logic              src_inc;
  logic              dst_inc;
  logic [CW-1:0]     chunk;
  logic [CW-1:0]     issued;
  logic [CW-1:0]     didx;
  logic              dp_valid;
  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];

  logic [ADDR_W-1:0] step;
  logic [CNT_W-1:0]  rem_next;
  logic              in_wr;
  logic              rd_phase;
  logic              cur_inc;
  logic [ADDR_W-1:0] cur_ptr;
  logic              issue_ok;
  logic              data_err;

  function automatic logic [CW-1:0] chunk_of(input logic [CNT_W-1:0] rem);
    if (rem >= CNT_W'(BUF_DEPTH)) return CW'(BUF_DEPTH);
    return rem[CW-1:0];
  endfunction

  assign step     = ADDR_W'(1) << hsize_q;
  assign rem_next = remaining - CNT_W'(chunk);
  assign in_wr    = (state == S_WR);
  assign rd_phase = (state == S_RD) || (state == S_RD_LAST);
  assign cur_inc  = in_wr ? dst_inc : src_inc;
  assign cur_ptr  = in_wr ? dst : src;
  assign issue_ok = ((state == S_RD) || in_wr) && Channel_en && (issued < chunk);
  assign data_err = dp_valid && (HResp == 2'b01);

  assign HSize    = {1'b0, hsize_q};
  assign C_config = (state != S_IDLE);
  assign irq      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      hsize_q   <= '0;
      src_inc   <= 1'b0;
      dst_inc   <= 1'b0;
      chunk     <= '0;
      issued    <= '0;
      didx      <= '0;
      dp_valid  <= 1'b0;
      HAddr     <= '0;
      HTrans    <= T_IDLE;
      HWrite    <= 1'b0;
      HWData    <= '0;
      err       <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_load) begin
            src       <= SAddr;
            dst       <= DAddr;
            remaining <= Trans_sz;
            hsize_q   <= (Ctrl[1:0] == 2'b11) ? 2'b10 : Ctrl[1:0];
            src_inc   <= Ctrl[2];
            dst_inc   <= Ctrl[3];
            err       <= 1'b0;
            state     <= S_CFG;
          end
        end
        S_CFG: begin
          if (Channel_en) begin
            if (remaining == '0) begin
              state <= S_DONE;
            end else begin
              chunk  <= chunk_of(remaining);
              issued <= '0;
              didx   <= '0;
              state  <= S_RD;
            end
          end
        end
        S_DONE: begin
          if (!Channel_en) state <= S_IDLE;
        end
        default: begin
          // Everything on the bus side advances only on HReady; low HReady is a full freeze.
          if (HReady) begin
            dp_valid <= HTrans[1];
            if (data_err) begin
              err      <= 1'b1;
              dp_valid <= 1'b0;
              HTrans   <= T_IDLE;
              HWrite   <= 1'b0;
              state    <= S_DONE;
            end else begin
              if (dp_valid && rd_phase) begin
                buf_mem[didx[PW-1:0]] <= HRData;
                didx                  <= didx + 1'b1;
              end
              // Write data is loaded as its address is accepted so it sits stable through the data phase.
              if (HTrans[1] && HWrite) begin
                HWData <= buf_mem[didx[PW-1:0]];
                didx   <= didx + 1'b1;
              end
              if (issue_ok) begin
                HAddr  <= cur_ptr;
                HTrans <= ((HTrans == T_IDLE) || !cur_inc) ? T_NONSEQ : T_SEQ;
                HWrite <= in_wr;
                issued <= issued + 1'b1;
                if (in_wr) dst <= dst + (dst_inc ? step : '0);
                else       src <= src + (src_inc ? step : '0);
              end else begin
                HTrans <= T_IDLE;
                HWrite <= 1'b0;
              end
              case (state)
                S_RD: if (issued == chunk) state <= S_RD_LAST;
                S_RD_LAST: begin
                  issued <= '0;
                  didx   <= '0;
                  state  <= S_WR;
                end
                S_WR: if (issued == chunk) state <= S_WR_LAST;
                S_WR_LAST: begin
                  remaining <= rem_next;
                  if (rem_next == '0) begin
                    state <= S_DONE;
                  end else begin
                    chunk  <= chunk_of(rem_next);
                    issued <= '0;
                    didx   <= '0;
                    state  <= S_RD;
                  end
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_channel.sv
// Directed bench for dmac_channel: an AHB slave model logs every accepted address phase and write
// data phase, returns address-derived read data, and can inject an ERROR on a chosen read.
module tb_dmac_channel;

  localparam logic [31:0] KEY = 32'h5A5A_0000;
  localparam logic [1:0]  TI = 2'b00, TN = 2'b10, TS = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [31:0] SAddr, DAddr;
  logic [15:0] Trans_sz;
  logic [3:0]  Ctrl;
  logic        Channel_en;
  logic        HReady;
  logic [1:0]  HResp;
  logic [31:0] HRData;
  logic [31:0] HAddr;
  logic [1:0]  HTrans;
  logic        HWrite;
  logic [2:0]  HSize;
  logic [31:0] HWData;
  logic        C_config, irq, err;

  always #5 clk = ~clk;

  dmac_channel dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .SAddr(SAddr), .DAddr(DAddr),
    .Trans_sz(Trans_sz), .Ctrl(Ctrl), .Channel_en(Channel_en), .HReady(HReady),
    .HResp(HResp), .HRData(HRData), .HAddr(HAddr), .HTrans(HTrans), .HWrite(HWrite),
    .HSize(HSize), .HWData(HWData), .C_config(C_config), .irq(irq), .err(err)
  );

  logic [31:0] al_addr  [256];
  logic [1:0]  al_trans [256];
  logic        al_write [256];
  logic [31:0] wl_addr  [256];
  logic [31:0] wl_data  [256];
  int          na = 0, nw = 0, nrd = 0;
  logic        dp_v = 1'b0, dp_w = 1'b0;
  logic [31:0] dp_a = '0;
  int          dp_rdn = 0;
  int          err_rd_idx = -1;

  always @(posedge clk) begin
    if (rst) begin
      dp_v <= 1'b0;
    end else if (HReady) begin
      if (dp_v && dp_w) begin
        wl_addr[nw] <= dp_a;
        wl_data[nw] <= HWData;
        nw          <= nw + 1;
      end
      dp_v <= HTrans[1];
      dp_a <= HAddr;
      dp_w <= HWrite;
      if (HTrans[1]) begin
        al_addr[na]  <= HAddr;
        al_trans[na] <= HTrans;
        al_write[na] <= HWrite;
        na           <= na + 1;
        if (!HWrite) begin
          dp_rdn <= nrd;
          nrd    <= nrd + 1;
        end
      end
    end
  end

  assign HResp  = (dp_v && !dp_w && dp_rdn == err_rd_idx) ? 2'b01 : 2'b00;
  assign HRData = (dp_v && !dp_w) ? (dp_a ^ KEY) : '0;

  int checks = 0;
  int errors = 0;
  int b_a, b_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_aph(input string tag, input int idx, input logic [31:0] a,
                         input logic [1:0] t, input logic w);
    chk(tag, {29'd0, al_trans[idx], al_write[idx], al_addr[idx]}, {29'd0, t, w, a});
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    chk(tag, {wl_addr[idx], wl_data[idx]}, {a, d});
  endtask

  task automatic do_cfg(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                        input logic [3:0] c);
    @(negedge clk);
    SAddr = s; DAddr = d; Trans_sz = n; Ctrl = c; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 300 && !irq; i++) @(negedge clk);
  endtask

  task automatic wait_na(input int target);
    for (int i = 0; i < 100 && na < target; i++) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int idx, beat, nwa;
    int chunks [3];
    chunks = '{4, 4, 2};
    rst = 1'b1; cfg_load = 1'b0; SAddr = '0; DAddr = '0; Trans_sz = '0; Ctrl = '0;
    Channel_en = 1'b0; HReady = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {HTrans, HWrite, HSize, C_config, irq, err}, '0);
    chk("reset_bus", {HAddr, HWData}, '0);
    rst = 1'b0;

    // case 1: 3 words, both incrementing
    b_a = na; b_w = nw;
    do_cfg(32'h100, 32'h200, 16'd3, 4'b1110);
    chk("t1_cconfig", C_config, 1);
    chk("t1_hsize", HSize, 3'd2);
    Channel_en = 1'b1;
    wait_irq();
    chk("t1_irq", {irq, err}, 2'b10);
    chk("t1_naph", na - b_a, 6);
    chk_aph("t1_a0", b_a + 0, 32'h100, TN, 1'b0);
    chk_aph("t1_a1", b_a + 1, 32'h104, TS, 1'b0);
    chk_aph("t1_a2", b_a + 2, 32'h108, TS, 1'b0);
    chk_aph("t1_a3", b_a + 3, 32'h200, TN, 1'b1);
    chk_aph("t1_a4", b_a + 4, 32'h204, TS, 1'b1);
    chk_aph("t1_a5", b_a + 5, 32'h208, TS, 1'b1);
    chk("t1_nwr", nw - b_w, 3);
    for (int i = 0; i < 3; i++)
      chk_wr("t1_wdata", b_w + i, 32'h200 + 32'(4 * i), (32'h100 + 32'(4 * i)) ^ KEY);
    Channel_en = 1'b0;
    @(negedge clk);
    chk("t1_release", {irq, C_config}, 2'b00);

    // case 2: 10 beats split 4,4,2
    b_a = na; b_w = nw;
    do_cfg(32'h1000, 32'h2000, 16'd10, 4'b1110);
    Channel_en = 1'b1;
    wait_irq();
    chk("t2_irq", irq, 1);
    chk("t2_naph", na - b_a, 20);
    idx = b_a; beat = 0;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < chunks[c]; j++) begin
        chk_aph("t2_rd", idx, 32'h1000 + 32'(4 * (beat + j)), (j == 0) ? TN : TS, 1'b0);
        idx++;
      end
      for (int j = 0; j < chunks[c]; j++) begin
        chk_aph("t2_wr", idx, 32'h2000 + 32'(4 * (beat + j)), (j == 0) ? TN : TS, 1'b1);
        idx++;
      end
      beat += chunks[c];
    end
    chk("t2_nwr", nw - b_w, 10);
    for (int i = 0; i < 10; i++)
      chk_wr("t2_wdata", b_w + i, 32'h2000 + 32'(4 * i), (32'h1000 + 32'(4 * i)) ^ KEY);
    Channel_en = 1'b0;
    @(negedge clk);

    // case 3: fixed addresses, every beat NONSEQ
    b_a = na; b_w = nw;
    do_cfg(32'h300, 32'h400, 16'd2, 4'b0010);
    Channel_en = 1'b1;
    wait_irq();
    chk("t3_naph", na - b_a, 4);
    chk_aph("t3_a0", b_a + 0, 32'h300, TN, 1'b0);
    chk_aph("t3_a1", b_a + 1, 32'h300, TN, 1'b0);
    chk_aph("t3_a2", b_a + 2, 32'h400, TN, 1'b1);
    chk_aph("t3_a3", b_a + 3, 32'h400, TN, 1'b1);
    chk_wr("t3_w1", b_w + 1, 32'h400, 32'h300 ^ KEY);
    Channel_en = 1'b0;
    @(negedge clk);

    // halfword stride
    b_a = na; b_w = nw;
    do_cfg(32'h500, 32'h700, 16'd2, 4'b1101);
    chk("t3h_hsize", HSize, 3'd1);
    Channel_en = 1'b1;
    wait_irq();
    chk_aph("t3h_a1", b_a + 1, 32'h502, TS, 1'b0);
    chk_aph("t3h_a3", b_a + 3, 32'h702, TS, 1'b1);
    chk_wr("t3h_w1", b_w + 1, 32'h702, 32'h502 ^ KEY);
    Channel_en = 1'b0;
    @(negedge clk);

    // case 4: wait states mid-read, pause mid-write
    b_a = na; b_w = nw;
    do_cfg(32'h100, 32'h200, 16'd3, 4'b1110);
    Channel_en = 1'b1;
    wait_na(b_a + 1);
    HReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_frozen", {HTrans, HAddr}, {TS, 32'h104});
    end
    HReady = 1'b1;
    wait_na(b_a + 4);
    chk("t4_pause_at", na - b_a, 4);
    Channel_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_paused", HTrans, TI);
    end
    chk("t4_pause_naph", na - b_a, 5);
    Channel_en = 1'b1;
    wait_irq();
    chk("t4_naph", na - b_a, 6);
    chk_aph("t4_a2", b_a + 2, 32'h108, TS, 1'b0);
    chk_aph("t4_a4", b_a + 4, 32'h204, TS, 1'b1);
    chk_aph("t4_a5", b_a + 5, 32'h208, TN, 1'b1);
    chk("t4_nwr", nw - b_w, 3);
    for (int i = 0; i < 3; i++)
      chk_wr("t4_wdata", b_w + i, 32'h200 + 32'(4 * i), (32'h100 + 32'(4 * i)) ^ KEY);
    Channel_en = 1'b0;
    @(negedge clk);

    // case 5: ERROR on second read data phase
    b_a = na; b_w = nw;
    do_cfg(32'h100, 32'h200, 16'd3, 4'b1110);
    err_rd_idx = nrd + 1;
    Channel_en = 1'b1;
    wait_irq();
    chk("t5_irq_err", {irq, err}, 2'b11);
    nwa = 0;
    for (int i = b_a; i < na; i++) if (al_write[i]) nwa++;
    chk("t5_no_wr_addr", nwa, 0);
    chk("t5_no_wr_data", nw - b_w, 0);
    err_rd_idx = -1;
    Channel_en = 1'b0;
    @(negedge clk);
    chk("t5_err_sticky", {C_config, err}, 2'b01);

    // case 6: zero-length transfer, then reset mid-read
    b_a = na;
    do_cfg(32'h800, 32'h900, 16'd0, 4'b1110);
    chk("t5_err_clear", {C_config, err}, 2'b10);
    Channel_en = 1'b1;
    @(negedge clk);
    chk("t6_zero_done", irq, 1);
    repeat (2) @(negedge clk);
    chk("t6_zero_idle", HTrans, TI);
    chk("t6_zero_naph", na - b_a, 0);
    Channel_en = 1'b0;
    @(negedge clk);
    chk("t6_zero_rel", {irq, C_config}, 2'b00);

    b_a = na;
    do_cfg(32'h100, 32'h200, 16'd3, 4'b1110);
    Channel_en = 1'b1;
    wait_na(b_a + 1);
    chk("t6_mid_rd", {HTrans, HAddr}, {TS, 32'h104});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_ctl", {HTrans, HWrite, HSize, C_config, irq, err}, '0);
    chk("t6_rst_bus", {HAddr, HWData}, '0);
    rst = 1'b0;
    Channel_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_after_rst", {HTrans, C_config}, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
